srl_fifo_bus: RTL

- Shift-register-addressed first-word-fall-through FIFO placed directly downstream of the fixed-latency SRL delay bus.
- Absorbs delayed bus words when the consumer stalls.
- The delay line cannot be halted mid-flight, so the FIFO raises almost_full early enough for the producer to stop issuing while words still in the delay line land safely.
- Storage is a shift chain: each write shifts all entries and inserts at index 0. Reads select entry count-1, so no write pointer exists.

---
 rtl/srl_fifo_bus_if.sv | 32 +++
 rtl/srl_fifo_bus.sv | 77 +++++++
 2 files changed

// File: rtl/srl_fifo_bus_if.sv
// srl_fifo_bus handshake bundle.
// master drives requests, slave is the FIFO.
interface srl_fifo_bus_if #(
  parameter int DW = 32,
  parameter int CW = 5
);
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          full;
  logic          almost_full;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          valid;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  modport master (
    output wr_en, data_in, rd_en,
    input  full, almost_full,
    input  data_out, valid, empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output full, almost_full,
    output data_out, valid, empty,
    output count, overflow, underflow
  );
endinterface

// File: rtl/srl_fifo_bus.sv
// FWFT FIFO behind the SRL delay bus.
// Shift-chain storage, head selected by count-1.
module srl_fifo_bus #(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_DEPTH        = 16,
  parameter int C_AFULL_MARGIN = 1
) (
  input  logic           clk,
  input  logic           rst,
  srl_fifo_bus_if.slave  bus
);
  localparam int CW = $clog2(C_DEPTH + 1);
  localparam int AW = $clog2(C_DEPTH);
  localparam logic [CW-1:0] FULL_LVL =
    CW'(C_DEPTH);
  localparam logic [CW-1:0] AF_LVL =
    CW'(C_DEPTH - C_AFULL_MARGIN);

  logic [C_DATA_WIDTH-1:0] srl [C_DEPTH];
  logic [CW-1:0]           cnt;
  logic                    ovf;
  logic                    udf;
  logic                    full;
  logic                    valid;
  logic                    wr_acc;
  logic                    rd_acc;
  logic [AW-1:0]           head_idx;

  assign full   = (cnt == FULL_LVL);
  assign valid  = (cnt != '0);
  assign wr_acc = bus.wr_en & ~full;
  assign rd_acc = bus.rd_en & valid;

  // count==C_DEPTH truncates to 0, so minus 1 lands on C_DEPTH-1
  assign head_idx = cnt[AW-1:0] - AW'(1);

  // no reset on storage so it maps onto shift-register primitives
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      srl[0] <= bus.data_in;
      for (int k = 1; k < C_DEPTH; k++)
        srl[k] <= srl[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      unique case (1'b1)
        wr_acc & ~rd_acc: cnt <= cnt + CW'(1);
        rd_acc & ~wr_acc: cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (bus.wr_en & full)   ovf <= 1'b1;
      if (bus.rd_en & ~valid) udf <= 1'b1;
    end
  end

  assign bus.count       = cnt;
  assign bus.full        = full;
  assign bus.almost_full = (cnt >= AF_LVL);
  assign bus.valid       = valid;
  assign bus.empty       = ~valid;
  assign bus.overflow    = ovf;
  assign bus.underflow   = udf;
  assign bus.data_out    =
    valid ? srl[head_idx] : '0;
endmodule
